// File: rtl/puf_key_sequencer.sv
// Time-multiplexes one PUF cell over the words of a wide challenge and builds
// a majority-voted key from VOTES evaluations of each word.
module puf_key_sequencer #(
    parameter int NUM_WORDS = 8,
    parameter int WORD_W    = 16,
    parameter int VOTES     = 5,
    parameter int TIMEOUT   = 4095
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_WORDS*WORD_W-1:0] challenge,
    output logic                        puf_start,
    output logic [WORD_W-1:0]           puf_challenge,
    input  logic                        puf_done,
    input  logic [WORD_W-1:0]           puf_response,
    output logic [NUM_WORDS*WORD_W-1:0] key_out,
    output logic                        key_valid,
    output logic                        busy,
    output logic                        error
);

    localparam int KW = NUM_WORDS * WORD_W;
    localparam int CW = 4;
    localparam int WW = $clog2(NUM_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE, ERR} state_t;

    state_t                       state_q, state_d;
    logic [KW-1:0]                chal_q, chal_d;
    logic [KW-1:0]                key_q, key_d;
    logic [WW-1:0]                w_q, w_d;
    logic [CW-1:0]                v_q, v_d;
    logic [WORD_W-1:0][CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]                tcnt_q, tcnt_d;
    logic                         key_valid_q, key_valid_d;
    logic                         busy_q, busy_d;
    logic                         error_q, error_d;
    logic [WORD_W-1:0]            vote_w;

    // A response bit wins when strictly more than half of the evaluations saw a one.
    always_comb begin
        vote_w = '0;
        for (int i = 0; i < WORD_W; i++) begin
            vote_w[i] = cnt_q[i] > CW'(VOTES / 2);
        end
    end

    // Word 0 sits in the most significant slice of the challenge.
    always_comb begin
        puf_challenge = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (w_q == WW'(k)) begin
                puf_challenge = chal_q[(NUM_WORDS-1-k)*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        chal_d      = chal_q;
        key_d       = key_q;
        w_d         = w_q;
        v_d         = v_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        key_valid_d = key_valid_q;
        busy_d      = busy_q;
        error_d     = error_q;
        puf_start   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    chal_d      = challenge;
                    key_valid_d = 1'b0;
                    error_d     = 1'b0;
                    w_d         = '0;
                    v_d         = '0;
                    cnt_d       = '0;
                    tcnt_d      = '0;
                    busy_d      = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                puf_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (puf_done) begin
                    for (int i = 0; i < WORD_W; i++) begin
                        cnt_d[i] = cnt_q[i] + CW'(puf_response[i]);
                    end
                    v_d     = v_q + CW'(1);
                    tcnt_d  = '0;
                    state_d = (v_d == CW'(VOTES)) ? NEXT : ISSUE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                    // Flags are raised on entry so error shows in the ERR cycle itself.
                    if (tcnt_d == TW'(TIMEOUT)) begin
                        error_d     = 1'b1;
                        busy_d      = 1'b0;
                        key_valid_d = 1'b0;
                        state_d     = ERR;
                    end
                end
            end
            NEXT: begin
                for (int k = 0; k < NUM_WORDS; k++) begin
                    if (w_q == WW'(k)) begin
                        key_d[(NUM_WORDS-1-k)*WORD_W +: WORD_W] = vote_w;
                    end
                end
                cnt_d   = '0;
                v_d     = '0;
                w_d     = w_q + WW'(1);
                state_d = (w_q == WW'(NUM_WORDS - 1)) ? DONE : ISSUE;
            end
            DONE: begin
                key_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            ERR: begin
                error_d     = 1'b1;
                busy_d      = 1'b0;
                key_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            chal_q      <= '0;
            key_q       <= '1;
            w_q         <= '0;
            v_q         <= '0;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            chal_q      <= chal_d;
            key_q       <= key_d;
            w_q         <= w_d;
            v_q         <= v_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    assign key_out   = key_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;
    assign error     = error_q;

endmodule
